// File: rtl/apb_slave_regs_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB3 slave register bank.
//   apb_state_e  : transfer FSM states (IDLE, ACCESS)
//   N_*_DEFAULT  : default register-bank geometry (N_REGS registers in total)
//   PHASE_*      : {PSEL, PENABLE} encodings of the APB SETUP and ACCESS phases
//   is_phase()   : compares the live bus phase against one of those encodings
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int N_RW_DEFAULT = 4;
    localparam int N_RO_DEFAULT = 2;
    localparam int N_REGS       = N_RW_DEFAULT + N_RO_DEFAULT;

    // Encodings are {PSEL, PENABLE}
    localparam logic [1:0] PHASE_SETUP  = 2'b10;
    localparam logic [1:0] PHASE_ACCESS = 2'b11;

    function automatic logic is_phase(input logic psel, input logic penable,
                                      input logic [1:0] phase);
        return ({psel, penable} == phase);
    endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// -----------------------------------------------------------------------------
// apb_slave_regs_if
// APB3 bus bundle between a master and the apb_slave_regs register bank.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : driven by the master
//   PRDATA, PREADY, PSLVERR              : driven by the slave
// -----------------------------------------------------------------------------
interface apb_slave_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regs_wait_ctrl.sv
// -----------------------------------------------------------------------------
// apb_wait_ctrl
// Transfer FSM and wait-state counter of the APB slave.
//   clk, rst  : clock and synchronous active-high reset
//   psel      : APB PSEL
//   penable   : APB PENABLE
//   state     : current FSM state (IDLE / ACCESS)
//   load      : SETUP accepted this cycle; parent latches address/data
//   pready    : APB PREADY
//   complete  : transfer finishes at the coming clock edge (same as pready)
// -----------------------------------------------------------------------------
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic       penable,
    output apb_state_e state,
    output logic       load,
    output logic       pready,
    output logic       complete
);

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: dropping PSEL in ACCESS abandons the transfer silently.
    // A malformed ACCESS cycle (PSEL=1, PENABLE=0) just holds the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        pready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_phase(psel, penable, PHASE_SETUP)) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (is_phase(psel, penable, PHASE_ACCESS)) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        pready  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state    = state_q;
    assign complete = pready;

endmodule

// File: rtl/apb_slave_regs.sv
// -----------------------------------------------------------------------------
// apb_slave_regs
// Parametrised APB3 slave register bank between the APB bus and the SPI core.
//   PCLK, PRESET : clock and synchronous active-high reset
//   apb          : APB slave bus (PSEL..PSLVERR)
//   data_out     : control registers, reg i at [i*DATA_W +: DATA_W]
//   data_in      : status inputs, status j at [j*DATA_W +: DATA_W]
//   wr_pulse     : one-cycle strobe per control register after a write
// Indices 0..N_RW-1 are RW control, N_RW..N_RW+N_RO-1 are RO status, any
// other index answers with PSLVERR.
// -----------------------------------------------------------------------------
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 4,
    parameter int              N_RW        = N_RW_DEFAULT,
    parameter int              N_RO        = N_REGS - N_RW_DEFAULT,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_slave_regs_if.slave        apb,
    output logic [N_RW*DATA_W-1:0] data_out,
    input  logic [N_RO*DATA_W-1:0] data_in,
    output logic [N_RW-1:0]        wr_pulse
);

    // One extra bit so N_RW+N_RO == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] RW_END  = (ADDR_W+1)'(N_RW);
    localparam logic [ADDR_W:0] REG_END = (ADDR_W+1)'(N_RW + N_RO);

    apb_state_e state;
    logic       load;
    logic       pready;
    logic       complete;

    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         write_q, write_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic [N_RW-1:0][DATA_W-1:0]  ctrl_q, ctrl_d;
    logic [N_RO-1:0][DATA_W-1:0]  shadow_q, shadow_d;
    logic [N_RW-1:0]              wr_pulse_q, wr_pulse_d;

    logic [ADDR_W:0]   idx_ext;
    logic              is_rw;
    logic              is_ro;
    logic              err;
    logic [DATA_W-1:0] rd_val;

    apb_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .clk      (PCLK),
        .rst      (PRESET),
        .psel     (apb.PSEL),
        .penable  (apb.PENABLE),
        .state    (state),
        .load     (load),
        .pready   (pready),
        .complete (complete)
    );

    // All sequential state of the bank
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            ctrl_q     <= {N_RW{RESET_VAL}};
            shadow_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            shadow_q   <= shadow_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Decode and read mux work on the index latched at SETUP, not live PADDR
    always_comb begin
        idx_ext = {1'b0, addr_q};
        is_rw   = (idx_ext < RW_END);
        is_ro   = !is_rw && (idx_ext < REG_END);
        err     = !(is_rw || is_ro) || (write_q && is_ro);
        rd_val  = '0;
        for (int i = 0; i < N_RW; i++) begin
            if (idx_ext == (ADDR_W+1)'(i)) rd_val = ctrl_q[i];
        end
        for (int j = 0; j < N_RO; j++) begin
            if (idx_ext == (ADDR_W+1)'(N_RW + j)) rd_val = shadow_q[j];
        end
    end

    // Holding registers, status shadow and write commit. The shadow keeps
    // following data_in while idle and freezes for the whole ACCESS phase.
    always_comb begin
        addr_d     = load ? apb.PADDR  : addr_q;
        write_d    = load ? apb.PWRITE : write_q;
        wdata_d    = load ? apb.PWDATA : wdata_q;
        shadow_d   = (state == IDLE) ? data_in : shadow_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        if (complete && write_q && !err) begin
            for (int i = 0; i < N_RW; i++) begin
                if (idx_ext == (ADDR_W+1)'(i)) begin
                    ctrl_d[i]     = wdata_q;
                    wr_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    assign apb.PREADY  = pready;
    assign apb.PSLVERR = complete && err;
    assign apb.PRDATA  = (complete && !write_q && !err) ? rd_val : '0;
    assign data_out    = ctrl_q;
    assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regs
// Self-checking bench for apb_slave_regs. Three instances (WAIT_CYCLES 0, 3
// and 2) share one set of bus drivers; dsel routes PSEL to one of them and
// selects whose outputs are observed.
// -----------------------------------------------------------------------------
module tb_apb_slave_regs;

    localparam logic [15:0] RST_VAL  = 16'h00A5;
    localparam logic [63:0] ALL_RST  = 64'h00A5_00A5_00A5_00A5;

    logic        clk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [15:0] pwdata = '0;
    logic [31:0] data_in = '0;
    int          dsel = 0;

    logic [63:0] dout_w0, dout_w3, dout_w2, dout_m;
    logic [3:0]  pulse_w0, pulse_w3, pulse_w2, pulse_m;
    logic [15:0] prdata_m;
    logic        pready_m, pslverr_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_slave_regs_if #(.ADDR_W(4), .DATA_W(16)) bus_w0 (), bus_w3 (), bus_w2 ();

    assign bus_w0.PSEL = psel && (dsel == 0);
    assign bus_w3.PSEL = psel && (dsel == 1);
    assign bus_w2.PSEL = psel && (dsel == 2);
    assign bus_w0.PENABLE = penable;
    assign bus_w3.PENABLE = penable;
    assign bus_w2.PENABLE = penable;
    assign bus_w0.PWRITE = pwrite;
    assign bus_w3.PWRITE = pwrite;
    assign bus_w2.PWRITE = pwrite;
    assign bus_w0.PADDR = paddr;
    assign bus_w3.PADDR = paddr;
    assign bus_w2.PADDR = paddr;
    assign bus_w0.PWDATA = pwdata;
    assign bus_w3.PWDATA = pwdata;
    assign bus_w2.PWDATA = pwdata;

    apb_slave_regs #(.DATA_W(16), .ADDR_W(4), .N_RW(4), .N_RO(2),
                     .WAIT_CYCLES(0), .RESET_VAL(RST_VAL)) dut_w0 (
        .PCLK(clk), .PRESET(preset), .apb(bus_w0),
        .data_out(dout_w0), .data_in(data_in), .wr_pulse(pulse_w0));

    apb_slave_regs #(.DATA_W(16), .ADDR_W(4), .N_RW(4), .N_RO(2),
                     .WAIT_CYCLES(3), .RESET_VAL(RST_VAL)) dut_w3 (
        .PCLK(clk), .PRESET(preset), .apb(bus_w3),
        .data_out(dout_w3), .data_in(data_in), .wr_pulse(pulse_w3));

    apb_slave_regs #(.DATA_W(16), .ADDR_W(4), .N_RW(4), .N_RO(2),
                     .WAIT_CYCLES(2), .RESET_VAL(RST_VAL)) dut_w2 (
        .PCLK(clk), .PRESET(preset), .apb(bus_w2),
        .data_out(dout_w2), .data_in(data_in), .wr_pulse(pulse_w2));

    // Observe whichever instance dsel points at
    always_comb begin
        case (dsel)
            0: begin
                dout_m = dout_w0; pulse_m = pulse_w0; prdata_m = bus_w0.PRDATA;
                pready_m = bus_w0.PREADY; pslverr_m = bus_w0.PSLVERR;
            end
            1: begin
                dout_m = dout_w3; pulse_m = pulse_w3; prdata_m = bus_w3.PRDATA;
                pready_m = bus_w3.PREADY; pslverr_m = bus_w3.PSLVERR;
            end
            default: begin
                dout_m = dout_w2; pulse_m = pulse_w2; prdata_m = bus_w2.PRDATA;
                pready_m = bus_w2.PREADY; pslverr_m = bus_w2.PSLVERR;
            end
        endcase
    end

    typedef struct {
        int          dut;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [31:0] din;
        int          exp_waits;
        logic        exp_err;
        logic [15:0] exp_rdata;
        logic [3:0]  exp_pulse;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // SETUP then ACCESS until PREADY; returns at the negedge of the
    // completion cycle with PSEL/PENABLE still high.
    task automatic doTransfer(input logic wr, input logic [3:0] addr,
                              input logic [15:0] wd, output int waits,
                              output logic err, output logic [15:0] rdata,
                              output logic [3:0] pulse_prev);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge clk);
        pulse_prev = pulse_m;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pready_m) break;
            waits++;
            @(posedge clk); #1;
        end
        err   = pslverr_m;
        rdata = prdata_m;
    endtask

    task automatic idleCycle(output logic [3:0] pulse, output logic [63:0] dout);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        pulse = pulse_m;
        dout  = dout_m;
    endtask

    task automatic applyStimulus(input int n, input vec_t v);
        int          waits;
        logic        err;
        logic [15:0] rdata;
        logic [3:0]  pprev;
        logic [3:0]  pulse;
        logic [63:0] dout;
        dsel    = v.dut;
        data_in = v.din;
        doTransfer(v.wr, v.addr, v.wdata, waits, err, rdata, pprev);
        checkOutput($sformatf("v%0d waits", n), 64'(waits), 64'(v.exp_waits));
        checkOutput($sformatf("v%0d pslverr", n), 64'(err), 64'(v.exp_err));
        if (!v.wr) checkOutput($sformatf("v%0d prdata", n), 64'(rdata), 64'(v.exp_rdata));
        idleCycle(pulse, dout);
        checkOutput($sformatf("v%0d wr_pulse", n), 64'(pulse), 64'(v.exp_pulse));
        checkOutput($sformatf("v%0d data_out", n), dout, v.exp_dout);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          waits;
        logic        err;
        logic [15:0] rdata;
        logic [3:0]  pprev;
        logic [3:0]  pulse;
        logic [63:0] dout;

        //         dut wr    addr  wdata     din            waits err   rdata     pulse    data_out
        vecs[0]  = '{0, 1'b1, 4'd2,  16'h1234, 32'h0,         0, 1'b0, 16'h0000, 4'b0100, 64'h00A5_1234_00A5_00A5};
        vecs[1]  = '{0, 1'b0, 4'd2,  16'h0000, 32'h0,         0, 1'b0, 16'h1234, 4'b0000, 64'h00A5_1234_00A5_00A5};
        vecs[2]  = '{0, 1'b1, 4'd5,  16'hFFFF, 32'h0,         0, 1'b1, 16'h0000, 4'b0000, 64'h00A5_1234_00A5_00A5};
        vecs[3]  = '{0, 1'b0, 4'd9,  16'h0000, 32'h0,         0, 1'b1, 16'h0000, 4'b0000, 64'h00A5_1234_00A5_00A5};
        vecs[4]  = '{0, 1'b0, 4'd4,  16'h0000, 32'h5678_9ABC, 0, 1'b0, 16'h9ABC, 4'b0000, 64'h00A5_1234_00A5_00A5};
        vecs[5]  = '{0, 1'b0, 4'd5,  16'h0000, 32'h5678_9ABC, 0, 1'b0, 16'h5678, 4'b0000, 64'h00A5_1234_00A5_00A5};
        vecs[6]  = '{0, 1'b1, 4'd0,  16'hCAFE, 32'h0,         0, 1'b0, 16'h0000, 4'b0001, 64'h00A5_1234_00A5_CAFE};
        vecs[7]  = '{1, 1'b1, 4'd3,  16'h0F0F, 32'h0,         3, 1'b0, 16'h0000, 4'b1000, 64'h0F0F_00A5_00A5_00A5};
        vecs[8]  = '{1, 1'b0, 4'd3,  16'h0000, 32'h0,         3, 1'b0, 16'h0F0F, 4'b0000, 64'h0F0F_00A5_00A5_00A5};
        vecs[9]  = '{1, 1'b0, 4'd15, 16'h0000, 32'h0,         3, 1'b1, 16'h0000, 4'b0000, 64'h0F0F_00A5_00A5_00A5};
        vecs[10] = '{1, 1'b1, 4'd4,  16'h1111, 32'h0,         3, 1'b1, 16'h0000, 4'b0000, 64'h0F0F_00A5_00A5_00A5};
        vecs[11] = '{2, 1'b0, 4'd1,  16'h0000, 32'h0,         2, 1'b0, 16'h00A5, 4'b0000, 64'h00A5_00A5_00A5_00A5};

        // Reset held for two edges, then every instance must sit at reset values
        preset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        preset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            #1;
            checkOutput($sformatf("reset%0d data_out", d), dout_m, ALL_RST);
            checkOutput($sformatf("reset%0d pready", d), 64'(pready_m), 64'd0);
            checkOutput($sformatf("reset%0d pslverr", d), 64'(pslverr_m), 64'd0);
            checkOutput($sformatf("reset%0d wr_pulse", d), 64'(pulse_m), 64'd0);
            checkOutput($sformatf("reset%0d prdata", d), 64'(prdata_m), 64'd0);
        end

        for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

        // Waited read must return the status sampled at SETUP
        $display("[TB] coherent waited read");
        dsel = 1;
        data_in = 32'h0000_BEEF;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'd4;
        @(posedge clk); #1;
        penable = 1'b1;
        data_in = 32'h0;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pready_m) break;
            waits++;
            @(posedge clk); #1;
        end
        checkOutput("beef waits", 64'(waits), 64'd3);
        checkOutput("beef prdata", 64'(prdata_m), 64'hBEEF);
        checkOutput("beef pslverr", 64'(pslverr_m), 64'd0);
        idleCycle(pulse, dout);

        // Back-to-back writes, each SETUP right after the previous completion
        $display("[TB] back-to-back writes");
        dsel = 0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_prev;
            doTransfer(1'b1, 4'(k), 16'(k + 1), waits, err, rdata, pprev);
            checkOutput($sformatf("b2b%0d waits", k), 64'(waits), 64'd0);
            checkOutput($sformatf("b2b%0d pslverr", k), 64'(err), 64'd0);
            if (k > 0) begin
                exp_prev = 4'b0001 << (k - 1);
                checkOutput($sformatf("b2b%0d prev pulse", k), 64'(pprev), 64'(exp_prev));
            end
        end
        idleCycle(pulse, dout);
        checkOutput("b2b last pulse", 64'(pulse), 64'b1000);
        checkOutput("b2b data_out", dout, 64'h0004_0003_0002_0001);
        idleCycle(pulse, dout);
        checkOutput("b2b pulse cleared", 64'(pulse), 64'd0);

        // Abort: PSEL dropped after the first ACCESS cycle
        $display("[TB] abort");
        dsel = 2;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 16'h1111;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checkOutput("abort acc1 pready", 64'(pready_m), 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        checkOutput("abort drop pready", 64'(pready_m), 64'd0);
        checkOutput("abort drop pslverr", 64'(pslverr_m), 64'd0);
        idleCycle(pulse, dout);
        checkOutput("abort wr_pulse", 64'(pulse), 64'd0);
        checkOutput("abort data_out", dout, ALL_RST);
        doTransfer(1'b0, 4'd1, 16'h0, waits, err, rdata, pprev);
        checkOutput("abort recover waits", 64'(waits), 64'd2);
        checkOutput("abort recover prdata", 64'(rdata), 64'h00A5);
        idleCycle(pulse, dout);

        // Reset in the middle of ACCESS restores RESET_VAL and drops the write
        $display("[TB] reset mid-transfer");
        doTransfer(1'b1, 4'd1, 16'h3333, waits, err, rdata, pprev);
        idleCycle(pulse, dout);
        checkOutput("pre-reset data_out", dout, 64'h00A5_00A5_3333_00A5);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 16'h4444;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        checkOutput("midreset data_out", dout_m, ALL_RST);
        checkOutput("midreset pready", 64'(pready_m), 64'd0);
        checkOutput("midreset wr_pulse", 64'(pulse_m), 64'd0);
        doTransfer(1'b0, 4'd1, 16'h0, waits, err, rdata, pprev);
        checkOutput("midreset read waits", 64'(waits), 64'd2);
        checkOutput("midreset read prdata", 64'(rdata), 64'h00A5);
        idleCycle(pulse, dout);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
